rv32i_fetch: RTL
================

RV32I_FETCH -- requirements
Module: rv32i_fetch

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port iaddr, output, 32, the instruction memory fetch address, always word aligned.
REQ-005 SHALL have port ireq, output, 1, the fetch request to the synchronous instruction ROM.
REQ-006 SHALL have port inst, input, 32, the ROM read data, valid exactly one cycle after an accepted ireq.
REQ-007 SHALL have port redirect, input, 1, a flush-and-jump request from the core.
REQ-008 SHALL have port redirect_pc, input, 32, the jump target.
REQ-009 SHALL have port o_inst, output, 32, the instruction at the queue head.
REQ-010 SHALL have port o_pc, output, 32, the address of o_inst.
REQ-011 SHALL have port o_valid, output, 1, meaning the queue head is valid.
REQ-012 SHALL have port i_ready, input, 1, the decode-stage accept signal.

Function
REQ-013 SHALL hold fetch_pc, a 3-entry FIFO of {pc, inst}, a 2-bit count, an inflight flag and inflight_pc.
REQ-014 SHALL drive iaddr = fetch_pc continuously, with bits [1:0] always 0.
REQ-015 SHALL drive ireq combinationally as ireq = !redirect && (count + inflight) < 3; the ROM has no backpressure, so every ireq is accepted.
REQ-016 On a clock edge with ireq=1, SHALL perform all of: inflight<=1; inflight_pc<=fetch_pc; fetch_pc<=fetch_pc+4.
REQ-017 fetch_pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-018 On a clock edge with inflight=1 and redirect=0, SHALL push {inflight_pc, inst} into the FIFO.
REQ-019 On a clock edge with inflight=1 and ireq=0, SHALL clear inflight.
REQ-020 SHALL define pop = o_valid && i_ready.
REQ-021 SHALL perform push and pop in the same cycle, leaving count unchanged and preserving order.
REQ-022 SHALL never overflow the FIFO; the credit rule in REQ-015 guarantees this, and the bench SHALL assert it.
REQ-023 SHALL drive o_valid = (count != 0) && !redirect.
REQ-024 SHALL drive o_inst and o_pc from the head entry; when the FIFO is empty they SHALL retain their last values.
REQ-025 SHALL sustain a throughput of one instruction per cycle when i_ready=1 continuously.
REQ-026 The latency from ireq to o_valid for that instruction SHALL be 2 clock edges.
REQ-027 On a redirect cycle, SHALL perform all of: flush the FIFO (count<=0); discard any inflight response; clear inflight; set fetch_pc<={redirect_pc[31:2],2'b00}; hold ireq=0.
REQ-028 The first fetch of the redirect target SHALL occur on the following cycle.
REQ-029 Redirect SHALL take priority over pop and push in the same cycle; a pop coinciding with redirect SHALL not count as accepted, since o_valid=0 in that cycle.
REQ-030 Back-to-back redirect cycles SHALL each apply; the last redirect_pc wins.

Reset
REQ-031 While rst_n=0, SHALL asynchronously force: fetch_pc=PC_RESET (bits [1:0] forced 0), count=0, inflight=0, inflight_pc=0, FIFO entries=0, o_inst=0, o_pc=0, o_valid=0.
REQ-032 While rst_n=0, ireq SHALL be 0.
REQ-033 SHALL assert ireq=1 with iaddr=PC_RESET in the first cycle after rst_n rises, synchronous to clk.
REQ-034 Reset asserted mid-operation SHALL discard all queued and inflight instructions immediately, with no output glitch once rst_n is low.

Verification
REQ-035 Reset release, i_ready=1, ROM returns inst=addr -> o_valid first high on the 2nd edge, then o_pc=0,4,8,C on consecutive cycles with o_inst=o_pc.
REQ-036 i_ready=0 for 6 cycles after reset -> exactly three ireq (0,4,8), ireq then low, count=3, no loss; raising i_ready -> o_pc 0,4,8,C in order, no bubble.
REQ-037 redirect=1, redirect_pc=32'h0000_0103 while inflight=1 and count=2 -> that cycle: o_valid=0, ireq=0; next cycle: iaddr=32'h100; next valid o_pc=32'h100; stale 8/C never appear.
REQ-038 PC_RESET=32'hFFFF_FFF8, i_ready=1 -> o_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-039 Alternating i_ready (1,0,1,0,...) for 20 cycles -> every address delivered exactly once in order; count never exceeds 3.
REQ-040 rst_n pulled low between clock edges while count=2 -> o_valid=0 and ireq=0 immediately; after release, fetch restarts at PC_RESET.

Source files
------------

// File: rtl/rv32i_fetch.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_fetch
// Description : RV32I instruction fetch unit. Issues word-aligned requests to
//               a synchronous instruction ROM (one-cycle read latency) and
//               buffers the returned instructions in a 3-entry in-order queue
//               that feeds the decode stage. A redirect flushes the queue,
//               drops any in-flight response and restarts fetch at the target.
// Ports       : clk          - clock, all state updates on rising edge
//               rst_n        - asynchronous active-low reset
//               iaddr        - ROM fetch address (word aligned)
//               ireq         - ROM fetch request
//               inst         - ROM read data, one cycle after ireq
//               redirect     - flush-and-jump request from the core
//               redirect_pc  - jump target
//               o_inst/o_pc  - instruction and address at the queue head
//               o_valid      - queue head valid
//               i_ready      - decode stage accepts the head this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] iaddr,
    output logic        ireq,
    input  logic [31:0] inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready
);

    localparam int          DEPTH       = 3;
    localparam logic [2:0]  C_CREDITS   = 3'd3;
    localparam logic [31:0] C_PC_RESET  = {PC_RESET[31:2], 2'b00};

    // Architectural state
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic [1:0]  count_q,       count_d;
    logic        inflight_q,    inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    // Shift-style queue: entry 0 is always the head
    logic [31:0] ent_pc_q   [DEPTH];
    logic [31:0] ent_pc_d   [DEPTH];
    logic [31:0] ent_inst_q [DEPTH];
    logic [31:0] ent_inst_d [DEPTH];
    // Last head shown, presented while the queue is empty
    logic [31:0] hold_pc_q,   hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    logic [2:0]  w_credits;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_wr_idx;

    // Requests in flight plus queued entries can never exceed the queue
    // depth, so every returning response has a slot waiting for it.
    assign w_credits = {1'b0, count_q} + {2'b00, inflight_q};
    assign ireq      = rst_n && !redirect && (w_credits < C_CREDITS);
    assign iaddr     = fetch_pc_q;

    assign o_valid   = (count_q != 2'd0) && !redirect;
    assign o_pc      = (count_q != 2'd0) ? ent_pc_q[0]   : hold_pc_q;
    assign o_inst    = (count_q != 2'd0) ? ent_inst_q[0] : hold_inst_q;

    assign w_push    = inflight_q && !redirect;
    assign w_pop     = o_valid && i_ready;
    // With a simultaneous pop the queue shifts down, so the new entry lands
    // one slot lower.
    assign w_wr_idx  = w_pop ? (count_q - 2'd1) : count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        ent_pc_d      = ent_pc_q;
        ent_inst_d    = ent_inst_q;
        hold_pc_d     = hold_pc_q;
        hold_inst_d   = hold_inst_q;

        if (count_q != 2'd0) begin
            hold_pc_d   = ent_pc_q[0];
            hold_inst_d = ent_inst_q[0];
        end

        if (redirect) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            if (ireq) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end else begin
                inflight_d    = 1'b0;
            end

            if (w_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    ent_pc_d[i]   = ent_pc_q[i+1];
                    ent_inst_d[i] = ent_inst_q[i+1];
                end
            end

            if (w_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (2'(i) == w_wr_idx) begin
                        ent_pc_d[i]   = inflight_pc_q;
                        ent_inst_d[i] = inst;
                    end
                end
            end

            count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= C_PC_RESET;
            count_q       <= 2'd0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            hold_pc_q     <= 32'd0;
            hold_inst_q   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]   <= 32'd0;
                ent_inst_q[i] <= 32'd0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_inst_q   <= hold_inst_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]   <= ent_pc_d[i];
                ent_inst_q[i] <= ent_inst_d[i];
            end
        end
    end

endmodule
`default_nettype wire
